// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// writeback_unit : scalar/vector RF write-back with a conv-result side FIFO
// Revision 1.0
// ============================================================================
module writeback_unit #(
    parameter int VW    = 128,
    parameter int SW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [VW-1:0]           conv_result,
    input  logic [4:0]              conv_addr,
    input  logic                    conv_write,
    input  logic [4:0]              rD,
    input  logic [SW-1:0]           s_result,
    input  logic [VW-1:0]           v_result,
    input  logic [SW-1:0]           smem,
    input  logic [VW-1:0]           vmem,
    input  logic                    ldr,
    input  logic [1:0]              wb,
    output logic                    s_we,
    output logic [4:0]              s_waddr,
    output logic [SW-1:0]           s_wdata,
    output logic                    v_we,
    output logic [4:0]              v_waddr,
    output logic [VW-1:0]           v_wdata,
    output logic                    conv_stall,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] c_FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] c_STALL_AT  = CW'(DEPTH - 1);
    localparam logic [1:0]    c_WB_SCALAR = 2'b01;
    localparam logic [1:0]    c_WB_VECTOR = 2'b10;

    // Conv FIFO storage; r_valid marks entries not yet superseded by an ALU/load write
    logic [VW-1:0]    r_data [DEPTH];
    logic [4:0]       r_addr [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic             w_scl_wr;
    logic             w_vec_wr;
    logic             w_empty;
    logic             w_full;
    logic             w_conv_squash;
    logic             w_conv_req;
    logic             w_pop;
    logic             w_bypass;
    logic             w_drop;
    logic             w_push;
    logic             w_head_valid;
    logic             w_v_issue;
    logic [4:0]       w_v_addr;
    logic [VW-1:0]    w_v_data;

    assign w_scl_wr      = (wb == c_WB_SCALAR);
    assign w_vec_wr      = (wb == c_WB_VECTOR);
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == c_FULL);
    assign w_conv_squash = conv_write && w_vec_wr && (conv_addr == rD);
    assign w_conv_req    = conv_write && !w_conv_squash;
    assign w_pop         = !w_vec_wr && !w_empty;
    assign w_bypass      = w_conv_req && !w_vec_wr && w_empty;
    assign w_drop        = w_conv_req && w_full && !w_pop;
    assign w_push        = w_conv_req && !w_bypass && !w_drop;
    assign w_head_valid  = r_valid[r_rd_ptr];

    assign conv_stall    = (r_count >= c_STALL_AT);
    assign fifo_count    = r_count;

    // Vector port arbitration: ALU/load, then FIFO head, then conv bypass
    always_comb begin
        w_v_issue = 1'b0;
        w_v_addr  = rD;
        w_v_data  = v_result;
        if (w_vec_wr) begin
            w_v_issue = 1'b1;
            w_v_addr  = rD;
            w_v_data  = ldr ? vmem : v_result;
        end else if (w_pop) begin
            w_v_issue = w_head_valid;
            w_v_addr  = r_addr[r_rd_ptr];
            w_v_data  = r_data[r_rd_ptr];
        end else if (w_bypass) begin
            w_v_issue = 1'b1;
            w_v_addr  = conv_addr;
            w_v_data  = conv_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_we     <= 1'b0;
            s_waddr  <= '0;
            s_wdata  <= '0;
            v_we     <= 1'b0;
            v_waddr  <= '0;
            v_wdata  <= '0;
            overflow <= 1'b0;
        end else begin
            s_we <= w_scl_wr;
            if (w_scl_wr) begin
                s_waddr <= rD;
                s_wdata <= ldr ? smem : s_result;
            end
            v_we <= w_v_issue;
            if (w_v_issue) begin
                v_waddr <= w_v_addr;
                v_wdata <= w_v_data;
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= conv_result;
            r_addr[r_wr_ptr] <= conv_addr;
        end
    end

    // A push into the slot being popped (full FIFO) must leave that slot valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == PW'(i))) begin
                    r_valid[i] <= 1'b1;
                end else if (w_pop && (r_rd_ptr == PW'(i))) begin
                    r_valid[i] <= 1'b0;
                end else if (w_vec_wr && (r_addr[i] == rD)) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// tb_writeback_unit : directed and randomized scoreboard bench for writeback_unit
module tb_writeback_unit;

    localparam int VW     = 128;
    localparam int SW     = 32;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 10;

    logic          clk;
    logic          reset;
    logic [VW-1:0] conv_result;
    logic [4:0]    conv_addr;
    logic          conv_write;
    logic [4:0]    rD;
    logic [SW-1:0] s_result;
    logic [VW-1:0] v_result;
    logic [SW-1:0] smem;
    logic [VW-1:0] vmem;
    logic          ldr;
    logic [1:0]    wb;
    logic          s_we;
    logic [4:0]    s_waddr;
    logic [SW-1:0] s_wdata;
    logic          v_we;
    logic [4:0]    v_waddr;
    logic [VW-1:0] v_wdata;
    logic          conv_stall;
    logic [2:0]    fifo_count;
    logic          overflow;

    writeback_unit #(.VW(VW), .SW(SW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .conv_result(conv_result), .conv_addr(conv_addr), .conv_write(conv_write),
        .rD(rD), .s_result(s_result), .v_result(v_result), .smem(smem), .vmem(vmem),
        .ldr(ldr), .wb(wb),
        .s_we(s_we), .s_waddr(s_waddr), .s_wdata(s_wdata),
        .v_we(v_we), .v_waddr(v_waddr), .v_wdata(v_wdata),
        .conv_stall(conv_stall), .fifo_count(fifo_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    typedef struct { logic [4:0] a; logic [VW-1:0] d; bit ok; } fent_t;
    typedef struct { time t; logic [4:0] a; logic [VW-1:0] d; } wr_t;

    // Reference model: pending conv entries plus expected RF writes with their edge time
    fent_t         fq[$];
    wr_t           vq[$];
    wr_t           sq[$];
    bit            m_ovf;
    logic [4:0]    m_saddr;
    logic [SW-1:0] m_sdata;
    bit            started;
    bit            prev_rst;
    int            n_tests;
    int            n_fail;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step(input bit rn, input logic [1:0] w, input logic [4:0] rd, input bit ld,
                        input bit cw, input logic [4:0] ca,
                        input logic [SW-1:0] sr, input logic [VW-1:0] vr,
                        input logic [SW-1:0] sm, input logic [VW-1:0] vm, input logic [VW-1:0] cr);
        time           t_next;
        bit            vec;
        bit            pop;
        int            n0;
        fent_t         e;
        logic [VW-1:0] tmp;
        @(posedge clk);
        #2;
        if (started) begin
            chk("fifo_count", fifo_count, fq.size());
            chk("conv_stall", conv_stall, (fq.size() >= DEPTH - 1));
            chk("overflow", overflow, m_ovf);
            chk("s_waddr", s_waddr, m_saddr);
            chk("s_wdata", s_wdata, m_sdata);
            if (prev_rst) begin
                chk("rst_v_we", v_we, 0);
                chk("rst_v_waddr", v_waddr, 0);
                chk("rst_v_wdata", v_wdata, 0);
                chk("rst_s_we", s_we, 0);
            end
        end
        reset = rn; wb = w; rD = rd; ldr = ld; conv_write = cw; conv_addr = ca;
        s_result = sr; v_result = vr; smem = sm; vmem = vm; conv_result = cr;
        t_next = $time - 2 + PERIOD;

        prev_rst = !rn;
        if (!rn) begin
            started = 1'b1;
            fq.delete();
            m_ovf   = 1'b0;
            m_saddr = '0;
            m_sdata = '0;
            return;
        end
        if (w == 2'b01) begin
            m_saddr = rd;
            m_sdata = ld ? sm : sr;
            tmp     = {{(VW-SW){1'b0}}, m_sdata};
            sq.push_back('{t_next, rd, tmp});
        end
        vec = (w == 2'b10);
        n0  = fq.size();
        pop = !vec && (n0 > 0);
        if (vec) begin
            tmp = ld ? vm : vr;
            vq.push_back('{t_next, rd, tmp});
            foreach (fq[i]) if (fq[i].a == rd) fq[i].ok = 1'b0;
        end
        if (pop) begin
            e = fq.pop_front();
            if (e.ok) vq.push_back('{t_next, e.a, e.d});
        end
        if (cw) begin
            if (vec && (ca == rd)) begin
                // younger ALU/load write to the same register wins
            end else if (!vec && (n0 == 0)) begin
                vq.push_back('{t_next, ca, cr});
            end else if ((n0 == DEPTH) && !pop) begin
                m_ovf = 1'b1;
            end else begin
                fq.push_back('{ca, cr, 1'b1});
            end
        end
    endtask

    task automatic rstep(input bit rn, input logic [1:0] w, input logic [4:0] rd, input bit ld,
                         input bit cw, input logic [4:0] ca);
        step(rn, w, rd, ld, cw, ca, $urandom, rnd128(), $urandom, rnd128(), rnd128());
    endtask

    // Monitor: compares every write the DUT presents against the scoreboard heads
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (v_we === 1'b1) begin
                if (vq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL v_write: got write addr %0d data %0h, expected no write", v_waddr, v_wdata);
                end else begin
                    e = vq.pop_front();
                    chk("v_time", $time - 1, e.t);
                    chk("v_waddr", v_waddr, e.a);
                    chk("v_wdata", v_wdata, e.d);
                end
            end else if (vq.size() > 0 && vq[0].t <= $time - 1) begin
                e = vq.pop_front();
                n_tests++; n_fail++;
                $display("FAIL v_missing: got v_we=%b, expected write addr %0d", v_we, e.a);
            end
            if (s_we === 1'b1) begin
                if (sq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL s_write: got write addr %0d, expected no write", s_waddr);
                end else begin
                    e = sq.pop_front();
                    chk("s_time", $time - 1, e.t);
                    chk("s_waddr_wr", s_waddr, e.a);
                    chk("s_wdata_wr", s_wdata, e.d);
                end
            end else if (sq.size() > 0 && sq[0].t <= $time - 1) begin
                e = sq.pop_front();
                n_tests++; n_fail++;
                $display("FAIL s_missing: got s_we=%b, expected write addr %0d", s_we, e.a);
            end
        end
    end

    initial begin
        bit         rn;
        bit         cw;
        logic [1:0] w;
        reset = 1'b0; wb = '0; rD = '0; ldr = 1'b0; conv_write = 1'b0; conv_addr = '0;
        s_result = '0; v_result = '0; smem = '0; vmem = '0; conv_result = '0;
        n_tests = 0; n_fail = 0; started = 1'b0; prev_rst = 1'b0; m_ovf = 1'b0;
        m_saddr = '0; m_sdata = '0;

        // reset held with a scalar write request, then a scalar ALU write
        rstep(0, 2'b01, 5'd3, 0, 0, 5'd0);
        rstep(0, 2'b01, 5'd3, 0, 0, 5'd0);
        step(1, 2'b01, 5'd3, 0, 0, 5'd0, 32'h12345678, rnd128(), $urandom, rnd128(), rnd128());
        // vector load then vector ALU write
        step(1, 2'b10, 5'd7, 1, 0, 5'd0, $urandom, rnd128(), $urandom, {16{8'hAA}}, rnd128());
        rstep(1, 2'b10, 5'd7, 0, 0, 5'd0);
        // conv bypass into an empty FIFO
        rstep(1, 2'b00, 5'd0, 0, 1, 5'd9);
        // four blocked conv writes, then in-order drain
        for (int i = 0; i < 4; i++) rstep(1, 2'b10, 5'd1, 0, 1, 5'(20 + i));
        for (int i = 0; i < 5; i++) rstep(1, 2'b00, 5'd0, 0, 0, 5'd0);
        // fill to DEPTH, one extra write overflows
        for (int i = 0; i < 5; i++) rstep(1, 2'b10, 5'd1, 0, 1, 5'(10 + i));
        for (int i = 0; i < 5; i++) rstep(1, 2'b00, 5'd0, 0, 0, 5'd0);
        // pending entry to reg 5 squashed by a younger ALU write
        rstep(1, 2'b10, 5'd1, 0, 1, 5'd5);
        step(1, 2'b10, 5'd5, 0, 0, 5'd0, $urandom, {16{8'h11}}, $urandom, rnd128(), rnd128());
        rstep(1, 2'b00, 5'd0, 0, 0, 5'd0);
        rstep(1, 2'b00, 5'd0, 0, 0, 5'd0);
        // same-cycle conv and ALU write to reg 6
        rstep(1, 2'b10, 5'd6, 0, 1, 5'd6);
        rstep(1, 2'b00, 5'd0, 0, 0, 5'd0);
        rstep(0, 2'b00, 5'd0, 0, 0, 5'd0);

        for (int k = 0; k < 800; k++) begin
            rn = ($urandom_range(0, 149) != 0);
            w  = 2'($urandom_range(0, 3));
            if (fq.size() >= DEPTH - 1) cw = ($urandom_range(0, 4) == 0);
            else                       cw = ($urandom_range(0, 9) < 6);
            rstep(rn, w, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), cw,
                  5'($urandom_range(0, 7)));
        end

        for (int i = 0; i < DEPTH + 3; i++) rstep(1, 2'b00, 5'd0, 0, 0, 5'd0);
        repeat (3) @(posedge clk);
        #3;
        chk("v_pending", vq.size(), 0);
        chk("s_pending", sq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
